// File: rtl/cha_wr_seq_if.sv
// Requester/slice bundle for the cache slice write sequencer: request side in,
// slice address/enable/pulse side out.
interface cha_wr_seq_if;
   localparam int unsigned ADR_W = 7;
   localparam int unsigned WAY_W = 2;
   localparam int unsigned WAY_N = 4;
   localparam int unsigned WD_W  = 2;
   localparam int unsigned WD_N  = 4;

   // Requesters
   logic               sweep_req_h;
   logic               fill_req_h;
   logic [WAY_W-1:0]   fill_way_h;
   logic [ADR_W-1:0]   fill_adr_h;
   logic               fill_wd_rdy_h;
   logic               wr_req_h;
   logic [WAY_W-1:0]   wr_way_h;
   logic [ADR_W-1:0]   wr_adr_h;
   logic [WD_W-1:0]    wr_wd_h;

   // Slice drive and completion
   logic [ADR_W-1:0]   csh_adr_h;
   logic [WAY_N-1:0]   csh_way_wr_en_l;
   logic [WD_N-1:0]    csh_wr_wd_en_h;
   logic               csh_wr_sel_all_h;
   logic               csh_wr_out_en_l;
   logic               csh_adr_wr_pulse_l;
   logic               csh_wr_wr_pulse_l;
   logic               fill_ack_h;
   logic               wr_ack_h;
   logic               sweep_done_h;
   logic               busy_h;

   modport master (
      output sweep_req_h, fill_req_h, fill_way_h, fill_adr_h, fill_wd_rdy_h,
             wr_req_h, wr_way_h, wr_adr_h, wr_wd_h,
      input  csh_adr_h, csh_way_wr_en_l, csh_wr_wd_en_h, csh_wr_sel_all_h,
             csh_wr_out_en_l, csh_adr_wr_pulse_l, csh_wr_wr_pulse_l,
             fill_ack_h, wr_ack_h, sweep_done_h, busy_h
   );

   modport slave (
      input  sweep_req_h, fill_req_h, fill_way_h, fill_adr_h, fill_wd_rdy_h,
             wr_req_h, wr_way_h, wr_adr_h, wr_wd_h,
      output csh_adr_h, csh_way_wr_en_l, csh_wr_wd_en_h, csh_wr_sel_all_h,
             csh_wr_out_en_l, csh_adr_wr_pulse_l, csh_wr_wr_pulse_l,
             fill_ack_h, wr_ack_h, sweep_done_h, busy_h
   );
endinterface

// File: rtl/cha_wr_seq.sv
// Write sequencer for one cache directory/data slice: arbitrates sweep, refill
// and core write-hit, giving every write a setup, pulse and hold cycle.
module cha_wr_seq (
   input  logic          clk_h,
   input  logic          reset_h,
   cha_wr_seq_if.slave   bus
);
   localparam int unsigned ADR_W = 7;
   localparam int unsigned WAY_W = 2;
   localparam int unsigned WAY_N = 4;
   localparam int unsigned WD_W  = 2;
   localparam int unsigned WD_N  = 4;

   localparam logic [ADR_W-1:0] SC_LAST = ADR_W'(127);
   localparam logic [WD_W-1:0]  WC_LAST = WD_W'(3);

   typedef enum logic [3:0] {
      IDLE,
      WR_SETUP, WR_PULSE, WR_HOLD,
      FD_SETUP, FD_PULSE, F_WAIT, FW_PULSE, F_DONE,
      SW_SETUP, SW_PULSE
   } state_e;

   typedef struct packed {
      logic [ADR_W-1:0] adr;
      logic [WAY_N-1:0] way_en_l;
      logic [WD_N-1:0]  wd_en;
      logic             sel_all;
      logic             out_en_l;
      logic             adr_pulse_l;
      logic             wr_pulse_l;
      logic             fill_ack;
      logic             wr_ack;
      logic             sweep_done;
      logic             busy;
   } csh_out_t;

   localparam csh_out_t OUT_RST = '{
      adr:         '0,
      way_en_l:    '1,
      wd_en:       '0,
      sel_all:     1'b0,
      out_en_l:    1'b1,
      adr_pulse_l: 1'b1,
      wr_pulse_l:  1'b1,
      fill_ack:    1'b0,
      wr_ack:      1'b0,
      sweep_done:  1'b0,
      busy:        1'b0
   };

   function automatic logic [WAY_N-1:0] onehot4(input logic [WAY_W-1:0] sel);
      onehot4 = 4'b0001 << sel;
   endfunction

   state_e           state_q, state_d;
   logic             sweep_pend_q, sweep_pend_d;
   logic [WD_W-1:0]  wc_q, wc_d;
   logic [ADR_W-1:0] sc_q, sc_d;
   logic [ADR_W-1:0] adr_q, adr_d;
   logic [WAY_W-1:0] way_q, way_d;
   logic [WD_W-1:0]  wd_q, wd_d;
   logic             sweep_done_d;
   csh_out_t         out_q, out_d;

   // State, counters, latched request context and registered slice drive
   always_ff @(posedge clk_h or posedge reset_h) begin
      if (reset_h) begin
         state_q      <= IDLE;
         sweep_pend_q <= 1'b0;
         wc_q         <= '0;
         sc_q         <= '0;
         adr_q        <= '0;
         way_q        <= '0;
         wd_q         <= '0;
         out_q        <= OUT_RST;
      end else begin
         state_q      <= state_d;
         sweep_pend_q <= sweep_pend_d;
         wc_q         <= wc_d;
         sc_q         <= sc_d;
         adr_q        <= adr_d;
         way_q        <= way_d;
         wd_q         <= wd_d;
         out_q        <= out_d;
      end
   end

   // Next state, then outputs decoded from the state being entered
   always_comb begin
      state_d      = state_q;
      sweep_pend_d = sweep_pend_q | bus.sweep_req_h;
      wc_d         = wc_q;
      sc_d         = sc_q;
      adr_d        = adr_q;
      way_d        = way_q;
      wd_d         = wd_q;
      sweep_done_d = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (sweep_pend_d) begin
               state_d      = SW_SETUP;
               sweep_pend_d = 1'b0;
               sc_d         = '0;
            end else if (bus.fill_req_h) begin
               state_d = FD_SETUP;
               wc_d    = '0;
               adr_d   = bus.fill_adr_h;
               way_d   = bus.fill_way_h;
            end else if (bus.wr_req_h) begin
               state_d = WR_SETUP;
               adr_d   = bus.wr_adr_h;
               way_d   = bus.wr_way_h;
               wd_d    = bus.wr_wd_h;
            end
         end
         WR_SETUP: state_d = WR_PULSE;
         WR_PULSE: state_d = WR_HOLD;
         WR_HOLD:  state_d = IDLE;
         FD_SETUP: state_d = FD_PULSE;
         FD_PULSE: state_d = F_WAIT;
         F_WAIT: begin
            if (bus.fill_wd_rdy_h) state_d = FW_PULSE;
         end
         FW_PULSE: begin
            wc_d    = wc_q + WD_W'(1);
            state_d = (wc_q == WC_LAST) ? F_DONE : F_WAIT;
         end
         F_DONE:   state_d = IDLE;
         SW_SETUP: state_d = SW_PULSE;
         SW_PULSE: begin
            sc_d = sc_q + ADR_W'(1);
            if (sc_q == SC_LAST) begin
               state_d      = IDLE;
               sweep_done_d = 1'b1;
            end else begin
               state_d = SW_SETUP;
            end
         end
         default:  state_d = IDLE;
      endcase

      // Index is held across IDLE so the slice address only moves on a new grant
      out_d            = OUT_RST;
      out_d.adr        = out_q.adr;
      out_d.busy       = (state_d != IDLE);
      out_d.sweep_done = sweep_done_d;

      unique case (state_d)
         WR_SETUP, WR_PULSE, WR_HOLD: begin
            out_d.adr        = adr_d;
            out_d.way_en_l   = ~onehot4(way_d);
            out_d.wd_en      = onehot4(wd_d);
            out_d.out_en_l   = 1'b0;
            out_d.wr_pulse_l = (state_d != WR_PULSE);
            out_d.wr_ack     = (state_d == WR_HOLD);
         end
         FD_SETUP, FD_PULSE: begin
            out_d.adr         = adr_d;
            out_d.way_en_l    = ~onehot4(way_d);
            out_d.adr_pulse_l = (state_d != FD_PULSE);
         end
         F_WAIT, FW_PULSE, F_DONE: begin
            // F_DONE is the hold cycle of the last word; wc has already wrapped
            out_d.adr        = adr_d;
            out_d.way_en_l   = ~onehot4(way_d);
            out_d.out_en_l   = 1'b0;
            out_d.wd_en      = onehot4((state_d == F_DONE) ? WC_LAST : wc_d);
            out_d.wr_pulse_l = (state_d != FW_PULSE);
            out_d.fill_ack   = (state_d == F_DONE);
         end
         SW_SETUP, SW_PULSE: begin
            out_d.adr         = sc_d;
            out_d.way_en_l    = '0;
            out_d.sel_all     = 1'b1;
            out_d.adr_pulse_l = (state_d != SW_PULSE);
         end
         default: ;
      endcase
   end

   assign bus.csh_adr_h          = out_q.adr;
   assign bus.csh_way_wr_en_l    = out_q.way_en_l;
   assign bus.csh_wr_wd_en_h     = out_q.wd_en;
   assign bus.csh_wr_sel_all_h   = out_q.sel_all;
   assign bus.csh_wr_out_en_l    = out_q.out_en_l;
   assign bus.csh_adr_wr_pulse_l = out_q.adr_pulse_l;
   assign bus.csh_wr_wr_pulse_l  = out_q.wr_pulse_l;
   assign bus.fill_ack_h         = out_q.fill_ack;
   assign bus.wr_ack_h           = out_q.wr_ack;
   assign bus.sweep_done_h       = out_q.sweep_done;
   assign bus.busy_h             = out_q.busy;
endmodule

// File: doc/cha_wr_seq.md
# cha_wr_seq

Write sequencer for one cache directory/data slice of the MBOX cache. It arbitrates among three requesters: the sweep engine, the refill path and the core write-hit path. It drives the slice's index, way enables, word enables and write pulses so that every directory or data write has one clean setup cycle, one pulse cycle and one hold cycle. All outputs are registered and feed the slice's `mbx_csh_adr_*`, `csh_*_wr_en_l`, `csh_wr_wd_*_en_h` and pulse inputs directly.

## Interface
- No parameters; geometry is fixed at 4 ways × 128 indices × 4 words.
- `clk_h` in 1: MBOX clock; all state changes on the rising edge.
- `reset_h` in 1: asynchronous, active-high reset.
- `sweep_req_h` in 1: one-cycle pulse requesting invalidation of every directory entry in all ways; latched as pending.
- `fill_req_h` in 1: level request for a refill; held until `fill_ack_h`.
- `fill_way_h` in 2: refill way.
- `fill_adr_h` in 7: refill index, mapping to address bits 27..33.
- `fill_wd_rdy_h` in 1: next refill word is valid on the data bus this cycle.
- `wr_req_h` in 1: level request for a single-word core write; held until `wr_ack_h`.
- `wr_way_h` in 2: core write way.
- `wr_adr_h` in 7: core write index.
- `wr_wd_h` in 2: core write word select.
- `csh_adr_h` out 7: index driven to `mbx_csh_adr_27..33_h`.
- `csh_way_wr_en_l` out 4: per-way enables, driving `csh_0..3_wr_en_l`.
- `csh_wr_wd_en_h` out 4: one-hot word enables.
- `csh_wr_sel_all_h` out 1: select-all-ways, used during sweep.
- `csh_wr_out_en_l` out 1: data write drivers enable.
- `csh_adr_wr_pulse_l` out 1: directory write pulse.
- `csh_wr_wr_pulse_l` out 1: data word write pulse.
- `fill_ack_h`, `wr_ack_h`, `sweep_done_h` out 1 each: one-cycle completion pulses.
- `busy_h` out 1: high whenever the state is not IDLE.

## Operation
- States:
  - IDLE
  - WR_SETUP, WR_PULSE, WR_HOLD
  - FD_SETUP, FD_PULSE, F_WAIT, FW_PULSE, F_DONE
  - SW_SETUP, SW_PULSE
- Grant happens only in IDLE. Priority is sweep pending > fill > wr. No preemption once granted.
- `sweep_pend` sets on `sweep_req_h` in any state. It clears on entry to SW_SETUP. A request that arrives during a sweep is not lost; it runs one more sweep afterwards.
- Core write sequence:
  - WR_SETUP: `csh_adr_h`=`wr_adr_h`, way bit low, word one-hot per `wr_wd_h`, `csh_wr_out_en_l`=0.
  - WR_PULSE: `csh_wr_wr_pulse_l`=0.
  - WR_HOLD: pulse high, enables still held, `wr_ack_h`=1.
  - Then IDLE with all enables deasserted.
- Refill sequence:
  - FD_SETUP: index and way enable driven.
  - FD_PULSE: `csh_adr_wr_pulse_l`=0; the directory tag and parity are written from PMA.
  - F_WAIT: holds index and way, `csh_wr_out_en_l`=0, word enable one-hot at word counter `wc`. `wc` resets to 0 at FD_SETUP.
  - F_WAIT → FW_PULSE when `fill_wd_rdy_h`=1. FW_PULSE: `csh_wr_wr_pulse_l`=0, then `wc`+1.
  - After the pulse with `wc`=3, go to F_DONE (`fill_ack_h`=1), otherwise back to F_WAIT.
  - `fill_wd_rdy_h` is ignored outside F_WAIT.
- Sweep sequence:
  - Index counter `sc` (7 bits) resets to 0.
  - SW_SETUP: `csh_adr_h`=`sc`, `csh_wr_sel_all_h`=1, all four `csh_way_wr_en_l`=0, word enables 0.
  - SW_PULSE: `csh_adr_wr_pulse_l`=0, `sc`+1.
  - After SW_PULSE with `sc`=127, `sweep_done_h`=1 and go to IDLE. `sc` wraps to 0.
- At most one of the two write pulses is low in any cycle. A pulse is never low in the same cycle that the index or an enable changes.

## Timing
- Reset values: `csh_adr_h`=0; all `_l` outputs 1; all `_h` outputs 0; state IDLE; `wc`=0; `sc`=0; `sweep_pend`=0.
- `reset_h` asserted mid-operation aborts the operation immediately and asynchronously deasserts any pulse. No ack is issued.
- Latency is measured from the grant edge, where IDLE samples the request:
  - Core write: pulse in cycle 2, ack in cycle 3, IDLE in cycle 4.
  - Refill: directory pulse in cycle 2. The earliest `fill_ack_h` is cycle 11 when `fill_wd_rdy_h` is held high, i.e. 2 cycles per word.
  - Sweep: 256 cycles; `sweep_done_h` in cycle 257.
- A requester may drop its request only after its ack. Request inputs are sampled only in IDLE.

## Test plan
- Reset, then `wr_req_h` with way 2, index 0x15, word 3:
  - `csh_way_wr_en_l`=4'b1011, `csh_wr_wd_en_h`=4'b1000, `csh_adr_h`=0x15.
  - `csh_wr_wr_pulse_l` low exactly one cycle, two cycles after grant.
  - `wr_ack_h` in the next cycle.
- Refill on way 0, index 0x7F, with `fill_wd_rdy_h` high only on alternate F_WAIT cycles:
  - One directory pulse, then four data pulses with word enables 0001, 0010, 0100, 1000.
  - `fill_ack_h` exactly once; the index is stable throughout.
- `sweep_req_h` pulse:
  - 128 directory pulses at indices 0..127 in order, with `csh_wr_sel_all_h`=1 and all ways enabled.
  - `sweep_done_h` 257 cycles after grant; `csh_wr_wr_pulse_l` never low.
- `fill_req_h`, `wr_req_h` and `sweep_req_h` all asserted in the same IDLE cycle:
  - Order is sweep, then fill, then write; each acked exactly once.
  - A second `sweep_req_h` during the sweep yields exactly one additional sweep.
- `reset_h` asserted during FW_PULSE of word 1:
  - Pulse deasserts without waiting for a clock edge; all outputs return to reset values.
  - No `fill_ack_h`. After release, a new refill starts cleanly at `wc`=0.
